uart_byte_receiver: RTL

Serial-to-parallel UART receiver, 8N1, LSB first, for the SoC's uart_rx pin; the receive-side counterpart of the SoC's uart_tx path. Synchronizes the asynchronous rx line, detects and validates the start bit, mid-bit samples 8 data bits, and checks the stop bit. Presents each received byte on a valid/ready interface to the SoC's memory-mapped UART register block, with framing-error and overrun reporting.

---
 rtl/uart_byte_receiver_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_byte_receiver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_receiver_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and default bit timing.
// Kept in a package so the transmitter can reuse the same constants.
package uart_byte_receiver_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line, plus falling-edge detect.
// All flops reset to 1 so that reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out = sync_r;
    assign fall     = prev_r & ~sync_r;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 LSB-first UART receiver with mid-bit sampling, framing-error and overrun
// reporting, delivering bytes on a valid/ready interface.
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam logic [COUNTER_WIDTH-1:0] FULL_TC = COUNTER_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [COUNTER_WIDTH-1:0] HALF_TC = COUNTER_WIDTH'((CLKS_PER_BIT / 2) - 1);

    rx_state_t              state_r;
    rx_state_t              state_next_s;
    logic [COUNTER_WIDTH-1:0] cnt_r;
    logic [2:0]             bit_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic [7:0]             out_data_r;
    logic                   out_valid_r;
    logic                   frame_error_r;
    logic                   overrun_r;
    logic                   busy_r;

    logic rx_s;
    logic fall_s;
    logic tick_s;
    logic cnt_run_s;
    logic shift_en_s;
    logic byte_done_s;
    logic frame_bad_s;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (uart_rx),
        .sync_out (rx_s),
        .fall     (fall_s)
    );

    // Sample strobe: half a bit to reach the start-bit centre, full bits afterwards
    always_comb begin
        tick_s = 1'b0;
        case (state_r)
            ST_START:         tick_s = (cnt_r == HALF_TC);
            ST_DATA, ST_STOP: tick_s = (cnt_r == FULL_TC);
            default:          tick_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_next_s = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_next_s = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM decoded controls for the datapath
    always_comb begin
        cnt_run_s   = 1'b0;
        shift_en_s  = 1'b0;
        byte_done_s = 1'b0;
        frame_bad_s = 1'b0;
        case (state_r)
            ST_START: cnt_run_s = 1'b1;
            ST_DATA: begin
                cnt_run_s  = 1'b1;
                shift_en_s = tick_s;
            end
            ST_STOP: begin
                cnt_run_s   = 1'b1;
                byte_done_s = tick_s & rx_s;
                frame_bad_s = tick_s & ~rx_s;
            end
            default: cnt_run_s = 1'b0;
        endcase
    end

    // Bit-period counter, cleared outside active states and at each strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (!cnt_run_s || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + COUNTER_WIDTH'(1);
        end
    end

    // Data bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx_r <= 3'd0;
            shift_r   <= '0;
        end else if (state_r != ST_DATA) begin
            bit_idx_r <= 3'd0;
            shift_r   <= shift_r;
        end else if (shift_en_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
        end else begin
            bit_idx_r <= bit_idx_r;
            shift_r   <= shift_r;
        end
    end

    // Output holding register, handshake and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r    <= 8'h00;
            out_valid_r   <= 1'b0;
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_error_r <= frame_bad_s;
            overrun_r     <= byte_done_s & out_valid_r & ~out_ready;
            busy_r        <= (state_next_s != ST_IDLE);
            if (byte_done_s) begin
                // A byte completing while the held one is still unread is dropped
                if (!out_valid_r || out_ready) begin
                    out_data_r  <= shift_r;
                    out_valid_r <= 1'b1;
                end else begin
                    out_data_r  <= out_data_r;
                    out_valid_r <= out_valid_r;
                end
            end else if (out_valid_r && out_ready) begin
                out_data_r  <= out_data_r;
                out_valid_r <= 1'b0;
            end else begin
                out_data_r  <= out_data_r;
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_data    = out_data_r;
    assign out_valid   = out_valid_r;
    assign frame_error = frame_error_r;
    assign overrun     = overrun_r;
    assign busy        = busy_r;

endmodule
